// File: rtl/button_debouncer.sv
// Pushbutton front end: per-button 2-FF synchronizer and debounce FSM, plus
// sticky press flags and a level interrupt for the MMIO block.

module button_debounce_lane #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic btn_i,
  output logic state_o,
  output logic press_o,
  output logic rel_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {RELEASED, PRESS_PEND, PRESSED, REL_PEND} state_e;

  state_e          st_q;
  logic [CW-1:0]   cnt_q;
  logic [1:0]      sync_q;
  logic            state_q, press_q, rel_q;
  logic            s;

  assign s       = sync_q[1];
  assign state_o = state_q;
  assign press_o = press_q;
  assign rel_o   = rel_q;

  // Any opposite sample while pending drops back without an event, so the
  // counter only ever runs over an unbroken stretch of the new level.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      st_q    <= RELEASED;
      cnt_q   <= '0;
      sync_q  <= '0;
      state_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      case (st_q)
        RELEASED: if (s) begin
          st_q  <= PRESS_PEND;
          cnt_q <= '0;
        end
        PRESS_PEND: begin
          if (!s) st_q <= RELEASED;
          else if (cnt_q == CNT_MAX) begin
            st_q    <= PRESSED;
            state_q <= 1'b1;
            press_q <= 1'b1;
          end else cnt_q <= cnt_q + 1'b1;
        end
        PRESSED: if (!s) begin
          st_q  <= REL_PEND;
          cnt_q <= '0;
        end
        REL_PEND: begin
          if (s) st_q <= PRESSED;
          else if (cnt_q == CNT_MAX) begin
            st_q    <= RELEASED;
            state_q <= 1'b0;
            rel_q   <= 1'b1;
          end else cnt_q <= cnt_q + 1'b1;
        end
        default: st_q <= RELEASED;
      endcase
    end
  end
endmodule

module button_debouncer #(
  parameter int NUM_BUTTONS     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [NUM_BUTTONS-1:0] btn_raw_i,
  output logic [NUM_BUTTONS-1:0] btn_state_o,
  output logic [NUM_BUTTONS-1:0] press_pulse_o,
  output logic [NUM_BUTTONS-1:0] rel_pulse_o,
  output logic [NUM_BUTTONS-1:0] press_flag_o,
  input  logic                   clr_valid_i,
  input  logic [NUM_BUTTONS-1:0] clr_mask_i,
  input  logic [NUM_BUTTONS-1:0] irq_mask_i,
  output logic                   btn_irq_o
);
  logic [NUM_BUTTONS-1:0] btn_pressed;
  logic [NUM_BUTTONS-1:0] press_flag_q, press_flag_d;
  logic                   btn_irq_q, btn_irq_d;

  assign btn_pressed = ACTIVE_LOW ? ~btn_raw_i : btn_raw_i;

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_lane
    button_debounce_lane #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lane (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .btn_i   (btn_pressed[i]),
      .state_o (btn_state_o[i]),
      .press_o (press_pulse_o[i]),
      .rel_o   (rel_pulse_o[i])
    );
  end

  // A press arriving with a clear in the same cycle must not be lost.
  always_comb begin
    press_flag_d = (press_flag_q & ~(clr_valid_i ? clr_mask_i : '0)) | press_pulse_o;
    btn_irq_d    = |(press_flag_q & irq_mask_i);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      press_flag_q <= '0;
      btn_irq_q    <= 1'b0;
    end else begin
      press_flag_q <= press_flag_d;
      btn_irq_q    <= btn_irq_d;
    end
  end

  assign press_flag_o = press_flag_q;
  assign btn_irq_o    = btn_irq_q;
endmodule

// File: tb/tb_button_debouncer.sv
// Randomized and directed checks of button_debouncer against a behavioural
// "level must differ for DEBOUNCE_CYCLES+1 samples" reference model.

module tb_button_debouncer;
  localparam int NB = 2;
  localparam int DC = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NB-1:0] btn_raw, btn_state, press_pulse, rel_pulse, press_flag;
  logic [NB-1:0] clr_mask, irq_mask, pressed;
  logic          clr_valid, btn_irq;

  always #5 clk = ~clk;

  button_debouncer #(.NUM_BUTTONS(NB), .DEBOUNCE_CYCLES(DC), .ACTIVE_LOW(1'b1)) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .btn_raw_i     (btn_raw),
    .btn_state_o   (btn_state),
    .press_pulse_o (press_pulse),
    .rel_pulse_o   (rel_pulse),
    .press_flag_o  (press_flag),
    .clr_valid_i   (clr_valid),
    .clr_mask_i    (clr_mask),
    .irq_mask_i    (irq_mask),
    .btn_irq_o     (btn_irq)
  );

  assign btn_raw = ~pressed;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: s is the pressed level two edges old; the debounced
  // level flips once s has disagreed with it for DC+1 consecutive edges.
  logic [NB-1:0] hist[$];
  logic [NB-1:0] m_db, m_pp, m_rp, m_flag;
  logic          m_irq;
  int            run[NB];

  // Directed-test observation counters.
  int cyc;
  int pp_cnt[NB], rp_cnt[NB], pp_at[NB], rp_at[NB];

  task automatic clr_counts();
    cyc = 0;
    for (int i = 0; i < NB; i++) begin
      pp_cnt[i] = 0; rp_cnt[i] = 0; pp_at[i] = -1; rp_at[i] = -1;
    end
  endtask

  task automatic model_edge();
    logic [NB-1:0] s, pp_n, rp_n, flag_n;
    logic          irq_n;
    if (reset) begin
      hist.delete();
      m_db = '0; m_pp = '0; m_rp = '0; m_flag = '0; m_irq = 1'b0;
      for (int i = 0; i < NB; i++) run[i] = 0;
      return;
    end
    s = (hist.size() >= 2) ? hist[hist.size()-2] : '0;
    hist.push_back(pressed);
    if (hist.size() > 4) void'(hist.pop_front());
    irq_n  = |(m_flag & irq_mask);
    flag_n = (m_flag & ~(clr_valid ? clr_mask : '0)) | m_pp;
    pp_n = '0; rp_n = '0;
    for (int i = 0; i < NB; i++) begin
      if (s[i] != m_db[i]) begin
        run[i]++;
        if (run[i] == DC + 1) begin
          m_db[i] = s[i];
          pp_n[i] = s[i];
          rp_n[i] = ~s[i];
          run[i]  = 0;
        end
      end else run[i] = 0;
    end
    m_pp = pp_n; m_rp = rp_n; m_flag = flag_n; m_irq = irq_n;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    chk("btn_state",   btn_state,   m_db);
    chk("press_pulse", press_pulse, m_pp);
    chk("rel_pulse",   rel_pulse,   m_rp);
    chk("press_flag",  press_flag,  m_flag);
    chk("btn_irq",     btn_irq,     m_irq);
    for (int i = 0; i < NB; i++) begin
      if (press_pulse[i]) begin pp_cnt[i]++; if (pp_at[i] < 0) pp_at[i] = cyc; end
      if (rel_pulse[i])   begin rp_cnt[i]++; if (rp_at[i] < 0) rp_at[i] = cyc; end
    end
  endtask

  task automatic run_n(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    pressed = '0; clr_valid = 1'b0; clr_mask = '0; irq_mask = '0;
    reset = 1'b1;
    run_n(3);
    chk("reset_outs", {btn_state, press_pulse, rel_pulse, press_flag, btn_irq}, '0);
    reset = 1'b0;
    irq_mask = 2'b01;
    run_n(5);

    // 1: clean press on button 0
    clr_counts();
    pressed[0] = 1'b1;
    run_n(7);
    chk("t1_pulse_now", press_pulse, 2'b01);
    run_n(1);
    chk("t1_flag", press_flag, 2'b01);
    run_n(1);
    chk("t1_irq", btn_irq, 1'b1);
    run_n(4);
    chk("t1_press_cnt", pp_cnt[0], 1);
    chk("t1_latency", pp_at[0], DC + 3);

    // 2: bounce on button 1, only the final stable level is accepted
    clr_counts();
    pressed[1] = 1'b1; run_n(3);
    pressed[1] = 1'b0; run_n(2);
    chk("t2_no_early", pp_cnt[1], 0);
    clr_counts();
    pressed[1] = 1'b1; run_n(12);
    chk("t2_press_cnt", pp_cnt[1], 1);
    chk("t2_latency", pp_at[1], DC + 3);
    chk("t2_no_rel", rp_cnt[1], 0);

    // 3: release button 0
    clr_counts();
    pressed[0] = 1'b0;
    run_n(12);
    chk("t3_rel_cnt", rp_cnt[0], 1);
    chk("t3_latency", rp_at[0], DC + 3);
    chk("t3_state", btn_state[0], 1'b0);
    chk("t3_flag_kept", press_flag[0], 1'b1);

    // 4: clear racing a new press pulse
    clr_valid = 1'b1; clr_mask = 2'b01; run_n(1);
    clr_valid = 1'b0; clr_mask = '0;    run_n(1);
    chk("t4_pre_clear", press_flag[0], 1'b0);
    pressed[0] = 1'b1;
    run_n(7);
    chk("t4_pulse", press_pulse[0], 1'b1);
    clr_valid = 1'b1; clr_mask = 2'b01; run_n(1);
    clr_valid = 1'b0; clr_mask = '0;
    chk("t4_set_wins", press_flag[0], 1'b1);
    run_n(2);
    clr_valid = 1'b1; clr_mask = 2'b01; run_n(1);
    clr_valid = 1'b0; clr_mask = '0;
    chk("t4_cleared", press_flag[0], 1'b0);
    run_n(1);
    chk("t4_irq_low", btn_irq, 1'b0);

    // 5: reset while button 0 is pending a press
    pressed[0] = 1'b0; run_n(12);
    clr_counts();
    pressed[0] = 1'b1; run_n(5);
    reset = 1'b1; run_n(1);
    chk("t5_reset_outs", {btn_state, press_pulse, rel_pulse, press_flag, btn_irq}, '0);
    chk("t5_no_pulse", pp_cnt[0], 0);
    clr_counts();
    reset = 1'b0;
    run_n(10);
    chk("t5_reaccept", pp_at[0], 2 + DC + 1);

    // 6: simultaneous press on both buttons, only button 1 raises irq
    pressed = '0; run_n(12);
    clr_valid = 1'b1; clr_mask = 2'b11; run_n(1);
    clr_valid = 1'b0; clr_mask = '0;
    irq_mask = 2'b10;
    clr_counts();
    pressed = 2'b11;
    run_n(7);
    chk("t6_both", press_pulse, 2'b11);
    run_n(3);
    chk("t6_same_cycle", pp_at[0], pp_at[1]);
    chk("t6_irq", btn_irq, 1'b1);
    clr_valid = 1'b1; clr_mask = 2'b10; run_n(1);
    clr_valid = 1'b0; clr_mask = '0;
    run_n(2);
    chk("t6_irq_masked", {press_flag, btn_irq}, 3'b010);

    // Random phase: slow-changing buttons give a mix of bounces and accepts.
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < NB; i++)
        if ($urandom_range(5) == 0) pressed[i] = ~pressed[i];
      clr_valid = ($urandom_range(7) == 0);
      clr_mask  = NB'($urandom);
      if ($urandom_range(49) == 0) irq_mask = NB'($urandom);
      reset = ($urandom_range(299) == 0);
      step();
    end
    reset = 1'b0;
    run_n(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
